lrwait_qnode_multi: RTL and testbench

// Per-core MCS-lock queue node with NumSlots independent LR/SC reservations. Sits between a

---
 rtl/lrwait_qnode_multi.sv | 163 ++++++++++++++++
 tb/tb_lrwait_qnode_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lrwait_qnode_multi.sv
// lrwait_qnode_multi: MCS-lock queue node tracking several LR/SC reservations and injecting WakeUp requests
module lrwait_qnode_multi #(
  parameter int unsigned NumSlots  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MetaWidth = 16,
  parameter int unsigned IdWidth   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   snitch_qaddr_i,
  input  logic                   snitch_qwrite_i,
  input  logic [3:0]             snitch_qamo_i,
  input  logic [DataWidth-1:0]   snitch_qdata_i,
  input  logic [DataWidth/8-1:0] snitch_qstrb_i,
  input  logic [IdWidth-1:0]     snitch_qid_i,
  input  logic                   snitch_qvalid_i,
  output logic                   snitch_qready_o,
  output logic [DataWidth-1:0]   snitch_pdata_o,
  output logic                   snitch_perror_o,
  output logic [IdWidth-1:0]     snitch_pid_o,
  output logic                   snitch_pvalid_o,
  input  logic                   snitch_pready_i,
  output logic [AddrWidth-1:0]   tile_qaddr_o,
  output logic                   tile_qwrite_o,
  output logic [3:0]             tile_qamo_o,
  output logic [DataWidth-1:0]   tile_qdata_o,
  output logic [DataWidth/8-1:0] tile_qstrb_o,
  output logic [IdWidth-1:0]     tile_qid_o,
  output logic                   tile_qlrwait_o,
  output logic                   tile_qvalid_o,
  input  logic                   tile_qready_i,
  input  logic [DataWidth-1:0]   tile_pdata_i,
  input  logic                   tile_perror_i,
  input  logic [IdWidth-1:0]     tile_pid_i,
  input  logic                   tile_plrwait_i,
  input  logic                   tile_pvalid_i,
  output logic                   tile_pready_o,
  output logic [NumSlots-1:0]    slot_busy_o,
  output logic                   err_o
);
  localparam int unsigned IdxW = NumSlots > 1 ? $clog2(NumSlots) : 1;
  localparam logic [3:0] AmoLr = 4'hA;
  localparam logic [3:0] AmoSc = 4'hB;
  typedef enum logic [2:0] {FREE, WAIT_LR, RESERVED, WAIT_SC, WAKE_UP} state_e;
  state_e               state_q [NumSlots];
  state_e               state_d [NumSlots];
  logic [AddrWidth-1:0] addr_q  [NumSlots];
  logic [AddrWidth-1:0] addr_d  [NumSlots];
  logic [IdWidth-1:0]   id_q    [NumSlots];
  logic [IdWidth-1:0]   id_d    [NumSlots];
  logic [MetaWidth-1:0] meta_q  [NumSlots];
  logic [MetaWidth-1:0] meta_d  [NumSlots];
  logic [NumSlots-1:0]  has_succ_q, has_succ_d;
  logic [NumSlots-1:0]  su_hit, sc_ok, sc_hit, rsp_hit;
  logic                 err_q, err_d;
  logic                 any_wake, any_free, dup, is_lr, is_sc, lr_stall, q_hs, p_hs, p_succ;
  logic [IdxW-1:0]      wake_idx, free_idx;

  always_comb begin
    any_wake = 1'b0;
    any_free = 1'b0;
    dup      = 1'b0;
    wake_idx = '0;
    free_idx = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (state_q[i] == WAKE_UP) begin
        any_wake = 1'b1;
        wake_idx = IdxW'(i);
      end
      if (state_q[i] == FREE) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
      if (state_q[i] != FREE && addr_q[i] == snitch_qaddr_i) dup = 1'b1;
    end
  end

  assign is_lr           = snitch_qamo_i == AmoLr;
  assign is_sc           = snitch_qamo_i == AmoSc;
  assign lr_stall        = is_lr && !any_free && !dup;
  assign snitch_qready_o = !any_wake && !lr_stall && tile_qready_i;
  assign q_hs            = snitch_qvalid_i && snitch_qready_o;
  assign tile_qvalid_o   = any_wake || (snitch_qvalid_i && !lr_stall);
  assign tile_qlrwait_o  = any_wake;
  assign tile_qaddr_o    = any_wake ? addr_q[wake_idx] : snitch_qaddr_i;
  assign tile_qwrite_o   = any_wake ? 1'b0 : snitch_qwrite_i;
  assign tile_qamo_o     = any_wake ? AmoLr : snitch_qamo_i;
  assign tile_qdata_o    = any_wake ? DataWidth'(meta_q[wake_idx]) : snitch_qdata_i;
  assign tile_qstrb_o    = any_wake ? '1 : snitch_qstrb_i;
  assign tile_qid_o      = any_wake ? id_q[wake_idx] : snitch_qid_i;

  assign p_succ          = tile_pvalid_i && tile_plrwait_i;
  assign snitch_pvalid_o = tile_pvalid_i && !tile_plrwait_i;
  assign snitch_pdata_o  = tile_pdata_i;
  assign snitch_perror_o = tile_perror_i;
  assign snitch_pid_o    = tile_pid_i;
  assign tile_pready_o   = tile_plrwait_i || snitch_pready_i;
  assign p_hs            = snitch_pvalid_o && snitch_pready_i;
  assign err_o           = err_q;

  for (genvar g = 0; g < NumSlots; g++) begin : gen_slot
    assign su_hit[g]      = p_succ && id_q[g] == tile_pid_i && state_q[g] != FREE && state_q[g] != WAKE_UP;
    assign sc_ok[g]       = state_q[g] == RESERVED && addr_q[g] == snitch_qaddr_i;
    assign sc_hit[g]      = q_hs && is_sc && sc_ok[g];
    assign rsp_hit[g]     = p_hs && id_q[g] == tile_pid_i;
    assign slot_busy_o[g] = state_q[g] != FREE;
  end

  always_comb begin
    err_d = (q_hs && is_lr && dup) || (q_hs && is_sc && !(|sc_ok)) || (p_succ && !(|su_hit));
    has_succ_d = has_succ_q;
    for (int i = 0; i < NumSlots; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      id_d[i]    = id_q[i];
      meta_d[i]  = meta_q[i];
      if (su_hit[i]) begin
        meta_d[i]     = tile_pdata_i[MetaWidth-1:0];
        has_succ_d[i] = 1'b1;
      end
      case (state_q[i])
        FREE: if (q_hs && is_lr && !dup && free_idx == IdxW'(i)) begin
          state_d[i]    = WAIT_LR;
          addr_d[i]     = snitch_qaddr_i;
          id_d[i]       = snitch_qid_i;
          has_succ_d[i] = 1'b0;
        end
        WAIT_LR: state_d[i] = rsp_hit[i] ? RESERVED : WAIT_LR;
        RESERVED: if (sc_hit[i]) begin
          id_d[i]    = snitch_qid_i;
          state_d[i] = (has_succ_q[i] || su_hit[i]) ? WAKE_UP : WAIT_SC;
        end
        WAIT_SC: state_d[i] = su_hit[i] ? WAKE_UP : rsp_hit[i] ? FREE : WAIT_SC;
        WAKE_UP: if (tile_qready_i && wake_idx == IdxW'(i)) begin
          state_d[i]    = FREE;
          has_succ_d[i] = 1'b0;
        end
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSlots; i++) begin
        state_q[i] <= FREE;
        addr_q[i]  <= '0;
        id_q[i]    <= '0;
        meta_q[i]  <= '0;
      end
      has_succ_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      meta_q     <= meta_d;
      has_succ_q <= has_succ_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_lrwait_qnode_multi.sv
// tb_lrwait_qnode_multi: directed self-checking bench for lrwait_qnode_multi
module tb_lrwait_qnode_multi;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] snitch_qaddr_i, snitch_qdata_i, snitch_pdata_o, tile_qaddr_o, tile_qdata_o, tile_pdata_i;
  logic        snitch_qwrite_i, snitch_qvalid_i, snitch_qready_o, snitch_perror_o, snitch_pvalid_o, snitch_pready_i;
  logic [3:0]  snitch_qamo_i, snitch_qstrb_i, tile_qamo_o, tile_qstrb_o;
  logic [4:0]  snitch_qid_i, snitch_pid_o, tile_qid_o, tile_pid_i;
  logic        tile_qwrite_o, tile_qlrwait_o, tile_qvalid_o, tile_qready_i;
  logic        tile_perror_i, tile_plrwait_i, tile_pvalid_i, tile_pready_o;
  logic [1:0]  slot_busy_o;
  logic        err_o;
  int          checks = 0;
  int          errors = 0;

  lrwait_qnode_multi dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .snitch_qaddr_i(snitch_qaddr_i), .snitch_qwrite_i(snitch_qwrite_i), .snitch_qamo_i(snitch_qamo_i),
    .snitch_qdata_i(snitch_qdata_i), .snitch_qstrb_i(snitch_qstrb_i), .snitch_qid_i(snitch_qid_i),
    .snitch_qvalid_i(snitch_qvalid_i), .snitch_qready_o(snitch_qready_o),
    .snitch_pdata_o(snitch_pdata_o), .snitch_perror_o(snitch_perror_o), .snitch_pid_o(snitch_pid_o),
    .snitch_pvalid_o(snitch_pvalid_o), .snitch_pready_i(snitch_pready_i),
    .tile_qaddr_o(tile_qaddr_o), .tile_qwrite_o(tile_qwrite_o), .tile_qamo_o(tile_qamo_o),
    .tile_qdata_o(tile_qdata_o), .tile_qstrb_o(tile_qstrb_o), .tile_qid_o(tile_qid_o),
    .tile_qlrwait_o(tile_qlrwait_o), .tile_qvalid_o(tile_qvalid_o), .tile_qready_i(tile_qready_i),
    .tile_pdata_i(tile_pdata_i), .tile_perror_i(tile_perror_i), .tile_pid_i(tile_pid_i),
    .tile_plrwait_i(tile_plrwait_i), .tile_pvalid_i(tile_pvalid_i), .tile_pready_o(tile_pready_o),
    .slot_busy_o(slot_busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] amo, input logic [4:0] id, input logic [31:0] d);
    snitch_qaddr_i  = a;
    snitch_qamo_i   = amo;
    snitch_qid_i    = id;
    snitch_qdata_i  = d;
    snitch_qstrb_i  = 4'hF;
    snitch_qwrite_i = 1'b0;
    snitch_qvalid_i = 1'b1;
    #1;
  endtask

  task automatic rsp(input logic lw, input logic [4:0] id, input logic [31:0] d);
    tile_plrwait_i = lw;
    tile_pid_i     = id;
    tile_pdata_i   = d;
    tile_pvalid_i  = 1'b1;
    #1;
  endtask

  task automatic idle;
    snitch_qvalid_i = 1'b0;
    snitch_qamo_i   = 4'h0;
    tile_pvalid_i   = 1'b0;
    tile_plrwait_i  = 1'b0;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    snitch_qaddr_i = '0; snitch_qdata_i = '0; snitch_qstrb_i = '0; snitch_qid_i = '0;
    snitch_qwrite_i = 1'b0; snitch_qamo_i = '0; snitch_qvalid_i = 1'b0; snitch_pready_i = 1'b1;
    tile_qready_i = 1'b1; tile_pdata_i = '0; tile_perror_i = 1'b0; tile_pid_i = '0;
    tile_plrwait_i = 1'b0; tile_pvalid_i = 1'b0;
    #2;
    check("rst_busy", slot_busy_o, 0);
    check("rst_err", err_o, 0);
    snitch_qvalid_i = 1'b1; #1;
    check("rst_pass_v1", tile_qvalid_o, 1);
    snitch_qvalid_i = 1'b0; #1;
    check("rst_pass_v0", tile_qvalid_o, 0);
    tick;
    rst_ni = 1'b1;
    tick;
    // plain LR/SC without successor
    req(32'h100, 4'hA, 5'd3, 0);
    check("t1_lr_ready", snitch_qready_o, 1);
    check("t1_lr_valid", tile_qvalid_o, 1);
    check("t1_lr_lrwait", tile_qlrwait_o, 0);
    check("t1_lr_addr", tile_qaddr_o, 32'h100);
    tick; idle;
    check("t1_busy", slot_busy_o, 2'b01);
    rsp(1'b0, 5'd3, 0);
    check("t1_lrresp_pv", snitch_pvalid_o, 1);
    tick; idle;
    req(32'h100, 4'hB, 5'd4, 0);
    tick; idle;
    check("t1_sc_err", err_o, 0);
    rsp(1'b0, 5'd4, 0);
    check("t1_scresp_pv", snitch_pvalid_o, 1);
    tick; idle;
    check("t1_free", slot_busy_o, 0);
    check("t1_no_wake", tile_qvalid_o, 0);
    check("t1_err", err_o, 0);
    // successor present -> WakeUp after SC
    req(32'h100, 4'hA, 5'd3, 0);
    tick; idle;
    snitch_pready_i = 1'b0;
    rsp(1'b1, 5'd3, 32'h0042);
    check("t2_su_pv", snitch_pvalid_o, 0);
    check("t2_su_pready", tile_pready_o, 1);
    tick; idle;
    snitch_pready_i = 1'b1;
    check("t2_su_err", err_o, 0);
    rsp(1'b0, 5'd3, 0);
    tick; idle;
    req(32'h100, 4'hB, 5'd4, 0);
    tick; idle;
    tile_qready_i = 1'b0;
    req(32'h700, 4'h0, 5'd9, 32'h1234);
    for (int c = 0; c < 2; c++) begin
      check("t2_wk_valid", tile_qvalid_o, 1);
      check("t2_wk_lrwait", tile_qlrwait_o, 1);
      check("t2_wk_amo", tile_qamo_o, 4'hA);
      check("t2_wk_addr", tile_qaddr_o, 32'h100);
      check("t2_wk_data", tile_qdata_o, 32'h42);
      check("t2_wk_id", tile_qid_o, 5'd4);
      check("t2_wk_qready", snitch_qready_o, 0);
      tick;
    end
    tile_qready_i = 1'b1; #1;
    check("t2_wk_qready_hs", snitch_qready_o, 0);
    tick;
    check("t2_after_free", slot_busy_o, 0);
    check("t2_pass_addr", tile_qaddr_o, 32'h700);
    check("t2_pass_lrwait", tile_qlrwait_o, 0);
    check("t2_pass_ready", snitch_qready_o, 1);
    tick; idle;
    rsp(1'b0, 5'd4, 0);
    check("t2_scresp_pv", snitch_pvalid_o, 1);
    tick; idle;
    // both slots held, third LR stalls
    req(32'h100, 4'hA, 5'd1, 0); tick;
    req(32'h200, 4'hA, 5'd2, 0); tick;
    req(32'h300, 4'hA, 5'd3, 0);
    check("t3_busy", slot_busy_o, 2'b11);
    check("t3_stall_ready", snitch_qready_o, 0);
    check("t3_stall_valid", tile_qvalid_o, 0);
    tick;
    check("t3_stall_ready2", snitch_qready_o, 0);
    idle;
    rsp(1'b0, 5'd1, 0); tick; idle;
    req(32'h100, 4'hB, 5'd5, 0); tick; idle;
    req(32'h300, 4'hA, 5'd3, 0);
    rsp(1'b0, 5'd5, 0);
    check("t3_stall_ready3", snitch_qready_o, 0);
    tick;
    tile_pvalid_i = 1'b0; #1;
    check("t3_freed_ready", snitch_qready_o, 1);
    tick; idle;
    check("t3_realloc", slot_busy_o, 2'b11);
    check("t3_err", err_o, 0);
    // both slots enter WakeUp together
    rsp(1'b0, 5'd3, 0); tick;
    rsp(1'b0, 5'd2, 0); tick;
    rsp(1'b1, 5'd3, 32'h0011); tick; idle;
    req(32'h200, 4'hB, 5'd6, 0); tick;
    req(32'h300, 4'hB, 5'd7, 0);
    rsp(1'b1, 5'd6, 32'h0022);
    tick; idle;
    tile_qready_i = 1'b0; #1;
    check("t4_err", err_o, 0);
    for (int c = 0; c < 3; c++) begin
      check("t4_s0_valid", tile_qvalid_o, 1);
      check("t4_s0_addr", tile_qaddr_o, 32'h300);
      check("t4_s0_data", tile_qdata_o, 32'h11);
      check("t4_s0_id", tile_qid_o, 5'd7);
      tick;
    end
    tile_qready_i = 1'b1;
    tick;
    check("t4_s1_busy", slot_busy_o, 2'b10);
    check("t4_s1_addr", tile_qaddr_o, 32'h200);
    check("t4_s1_data", tile_qdata_o, 32'h22);
    check("t4_s1_id", tile_qid_o, 5'd6);
    check("t4_s1_lrwait", tile_qlrwait_o, 1);
    tick;
    check("t4_done_busy", slot_busy_o, 0);
    check("t4_done_valid", tile_qvalid_o, 0);
    // error cases
    req(32'h500, 4'hB, 5'd8, 32'hDEAD);
    check("t5_sc_valid", tile_qvalid_o, 1);
    check("t5_sc_addr", tile_qaddr_o, 32'h500);
    check("t5_sc_amo", tile_qamo_o, 4'hB);
    check("t5_sc_data", tile_qdata_o, 32'hDEAD);
    check("t5_sc_ready", snitch_qready_o, 1);
    tick; idle;
    check("t5_sc_err", err_o, 1);
    tick;
    check("t5_sc_err_pulse", err_o, 0);
    rsp(1'b1, 5'd7, 32'h0033);
    check("t5_su_pv", snitch_pvalid_o, 0);
    check("t5_su_pready", tile_pready_o, 1);
    tick; idle;
    check("t5_su_err", err_o, 1);
    check("t5_su_busy", slot_busy_o, 0);
    tick;
    check("t5_su_err_pulse", err_o, 0);
    req(32'h100, 4'hA, 5'd1, 0); tick;
    req(32'h100, 4'hA, 5'd2, 0);
    check("t5_dup_ready", snitch_qready_o, 1);
    tick; idle;
    check("t5_dup_err", err_o, 1);
    check("t5_dup_busy", slot_busy_o, 2'b01);
    req(32'h100, 4'hB, 5'd3, 0);
    tick; idle;
    check("t5_sc_waitlr_err", err_o, 1);
    // reset while in WakeUp
    rsp(1'b0, 5'd1, 0); tick;
    rsp(1'b1, 5'd1, 32'h5); tick; idle;
    req(32'h100, 4'hB, 5'd9, 0); tick; idle;
    tile_qready_i = 1'b0; #1;
    check("t6_wake_valid", tile_qvalid_o, 1);
    check("t6_wake_busy", slot_busy_o, 2'b01);
    rst_ni = 1'b0; #1;
    check("t6_rst_busy", slot_busy_o, 0);
    check("t6_rst_valid0", tile_qvalid_o, 0);
    snitch_qvalid_i = 1'b1; #1;
    check("t6_rst_valid1", tile_qvalid_o, 1);
    check("t6_rst_lrwait", tile_qlrwait_o, 0);
    tick;
    rst_ni = 1'b1;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
